// File: rtl/screen_box_scanner.sv
// screen_box_scanner
//   Framebuffer-side stage that sits directly after the triangle rasteriser.
//   On a rising edge of screen_start it latches a bounding box, then visits
//   every pixel in it, row-major. Each pixel takes three cycles:
//     READ  : present the address to the synchronous framebuffer RAM
//     LATCH : capture the old colour from the RAM
//     WRITE : write back whatever colour the rasteriser returns
//   Pixels outside the visible screen still take the same three cycles,
//   but they are never written. screen_done pulses for one cycle at the end.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   screen_start          : level request; its rising edge starts a box
//   screen_x_min/y_min    : top-left corner of the box
//   screen_x_range/y_range: box width/height minus one (inclusive)
//   new_screen_colour     : colour from the rasteriser for the current pixel
//   screen_x/screen_y     : current pixel coordinates
//   old_screen_colour     : framebuffer colour at the current pixel
//   screen_done           : one-cycle completion pulse
//   busy                  : high from accept through the done cycle
//   mem_addr/mem_rdata    : framebuffer read port (1-cycle read latency)
//   mem_wdata/mem_we      : framebuffer write port
module screen_box_scanner #(
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = 3,
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120,
  parameter int ADDR_WIDTH   = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    screen_start,
  input  logic [WIDTH-1:0]        screen_x_min,
  input  logic [WIDTH-1:0]        screen_y_min,
  input  logic [WIDTH-1:0]        screen_x_range,
  input  logic [WIDTH-1:0]        screen_y_range,
  input  logic [COLOUR_WIDTH-1:0] new_screen_colour,
  output logic [WIDTH-1:0]        screen_x,
  output logic [WIDTH-1:0]        screen_y,
  output logic [COLOUR_WIDTH-1:0] old_screen_colour,
  output logic                    screen_done,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [COLOUR_WIDTH-1:0] mem_rdata,
  output logic [COLOUR_WIDTH-1:0] mem_wdata,
  output logic                    mem_we
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    start_d_q, start_d_d;
  logic [WIDTH-1:0]        xc_q, xc_d;
  logic [WIDTH-1:0]        yc_q, yc_d;
  logic [COLOUR_WIDTH-1:0] old_q, old_d;
  logic [WIDTH-1:0]        x_min_q, x_min_d;
  logic [WIDTH-1:0]        y_min_q, y_min_d;
  logic [WIDTH-1:0]        x_range_q, x_range_d;
  logic [WIDTH-1:0]        y_range_q, y_range_d;

  logic [WIDTH:0]          sum_x;
  logic [WIDTH:0]          sum_y;
  logic                    on_screen;
  logic                    start_edge;

  // Control state and the counters are reset; the latched box is plain data
  // and is always reloaded on accept before it is used.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      start_d_q <= 1'b0;
      xc_q      <= '0;
      yc_q      <= '0;
      old_q     <= '0;
    end else begin
      state_q   <= state_d;
      start_d_q <= start_d_d;
      xc_q      <= xc_d;
      yc_q      <= yc_d;
      old_q     <= old_d;
    end
    x_min_q   <= x_min_d;
    y_min_q   <= y_min_d;
    x_range_q <= x_range_d;
    y_range_q <= y_range_d;
  end

  // Sums carry one extra bit: a carry out means the pixel wrapped past the
  // coordinate range and is therefore off-screen. Comparing the full
  // WIDTH+1-bit sum against the screen size covers both cases at once.
  always_comb begin
    sum_x     = {1'b0, x_min_q} + {1'b0, xc_q};
    sum_y     = {1'b0, y_min_q} + {1'b0, yc_q};
    on_screen = (sum_x < (WIDTH+1)'(SCREEN_W)) && (sum_y < (WIDTH+1)'(SCREEN_H));
    screen_x  = sum_x[WIDTH-1:0];
    screen_y  = sum_y[WIDTH-1:0];
    mem_addr  = ADDR_WIDTH'(sum_y[WIDTH-1:0]) * ADDR_WIDTH'(SCREEN_W)
              + ADDR_WIDTH'(sum_x[WIDTH-1:0]);
  end

  assign start_edge        = screen_start & ~start_d_q;
  assign old_screen_colour = old_q;
  assign mem_wdata         = new_screen_colour;

  always_comb begin
    state_d     = state_q;
    start_d_d   = screen_start;
    xc_d        = xc_q;
    yc_d        = yc_q;
    old_d       = old_q;
    x_min_d     = x_min_q;
    y_min_d     = y_min_q;
    x_range_d   = x_range_q;
    y_range_d   = y_range_q;
    mem_we      = 1'b0;
    screen_done = 1'b0;
    busy        = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          x_min_d   = screen_x_min;
          y_min_d   = screen_y_min;
          x_range_d = screen_x_range;
          y_range_d = screen_y_range;
          xc_d      = '0;
          yc_d      = '0;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        old_d   = mem_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_we  = on_screen;
        state_d = S_READ;
        // Equality compares keep a full-range box (range = all ones) from
        // wrapping the counter and looping forever.
        if (xc_q != x_range_q) begin
          xc_d = xc_q + WIDTH'(1);
        end else begin
          xc_d = '0;
          if (yc_q != y_range_q) begin
            yc_d = yc_q + WIDTH'(1);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        screen_done = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/screen_box_scanner.md
Name: screen_box_scanner

Overview:
- Framebuffer-side stage directly downstream of the triangle rasteriser; implements the "screen interface" that the rasteriser drives.
- On start, latches a bounding box and walks every pixel in it, row-major.
- For each pixel it reads the old colour from the framebuffer RAM, presents (x, y, old colour) to the rasteriser, and writes back the colour the rasteriser returns. The write is a read-modify-write.
- Pulses done when the box is finished.

Parameters:
- WIDTH, 8, coordinate and range width.
- COLOUR_WIDTH, 3, pixel colour width.
- SCREEN_W, 160, visible columns; x >= SCREEN_W is off-screen.
- SCREEN_H, 120, visible rows; y >= SCREEN_H is off-screen.
- ADDR_WIDTH, 15, framebuffer address width; must satisfy 2^ADDR_WIDTH >= SCREEN_W*SCREEN_H.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- screen_start  in  1  level request; a rising edge starts a box.
- screen_x_min  in  WIDTH  box left edge.
- screen_y_min  in  WIDTH  box top edge.
- screen_x_range  in  WIDTH  box width minus 1 (inclusive).
- screen_y_range  in  WIDTH  box height minus 1 (inclusive).
- new_screen_colour  in  COLOUR_WIDTH  colour to write for current pixel (combinational from rasteriser).
- screen_x  out  WIDTH  current pixel x.
- screen_y  out  WIDTH  current pixel y.
- old_screen_colour  out  COLOUR_WIDTH  framebuffer colour at current pixel.
- screen_done  out  1  one-cycle pulse when the box completes.
- busy  out  1  high from accept until the done cycle, inclusive.
- mem_addr  out  ADDR_WIDTH  framebuffer address = screen_y*SCREEN_W + screen_x.
- mem_rdata  in  COLOUR_WIDTH  synchronous RAM read data, valid 1 cycle after mem_addr.
- mem_wdata  out  COLOUR_WIDTH  write data.
- mem_we  out  1  write enable.

Behaviour:
- States: S_IDLE, S_READ, S_LATCH, S_WRITE, S_DONE.
- Reset (any state, including mid-box):
  - state=S_IDLE; x/y counters=0; old_screen_colour=0.
  - screen_done=0, busy=0, mem_we=0, start edge register=0.
  - No further writes; completed writes are not undone.
- Start detect:
  - Register start_d <= screen_start.
  - Accept only in S_IDLE when screen_start & ~start_d.
  - A level held high after done does not retrigger. Edges while busy are ignored.
- Accept:
  - Latch x_min, y_min, x_range, y_range.
  - xc=0, yc=0; go to S_READ.
  - Later input changes have no effect until the next accept.
- Pixel coordinates:
  - screen_x = x_min_l + xc; screen_y = y_min_l + yc.
  - Each sum is computed in WIDTH+1 bits. A carry-out marks the pixel off-screen; screen_x/screen_y are the low WIDTH bits.
  - Coordinates are stable through READ/LATCH/WRITE of a pixel.
- S_READ:
  - mem_addr valid; go to S_LATCH.
- S_LATCH:
  - old_screen_colour <= mem_rdata; go to S_WRITE.
- S_WRITE:
  - mem_wdata = new_screen_colour.
  - mem_we = 1 only if on-screen (x < SCREEN_W and y < SCREEN_H, no carry); otherwise mem_we = 0.
  - Off-screen pixels still take 3 cycles, so timing is uniform.
  - Advance: if xc != x_range_l then xc+1. Else xc=0 and, if yc != y_range_l, yc+1, else go to S_DONE.
  - Next state is S_READ unless done.
- S_DONE:
  - screen_done=1 for exactly this cycle; go to S_IDLE.
- Latency:
  - Box of N=(x_range+1)*(y_range+1) pixels.
  - Accept at edge k; screen_done is high in the cycle starting at edge k+3N; busy low from edge k+3N+1.
- mem_we is 0 in every state except S_WRITE.
- old_screen_colour holds its last value in S_IDLE.
- mem_addr is don't-care when off-screen; it must not be used since mem_we=0.
- Range 0 in both axes gives a single pixel.
- Maximum ranges (2^WIDTH-1) must not deadlock; counters are WIDTH bits, compared by equality.

Test Plan:
- 1x1 box: x_min=5, y_min=7, ranges 0, RAM[7*160+5]=2, new_colour=6 → exactly one write addr 1125 data 6; screen_done 3 cycles after accept; busy high 4 cycles.
- 3x2 box: x_min=10, y_min=20, x_range=2, y_range=1 → write sequence (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); 6 writes; done at accept+18.
- Read-modify-write: rasteriser model returns old colour when not plotting; RAM preloaded with pattern → RAM unchanged after box; old_screen_colour equals preload at each S_WRITE.
- Clipping: x_min=158, x_range=3, y_min=119, y_range=1 → writes only (158,119),(159,119); 8 pixels visited; done at accept+24.
- Reset mid-box: assert reset during the 2nd pixel's S_LATCH of a 4x1 box → mem_we never high again; only pixel 0 written; busy=0 and done=0 next cycle.
- Start held: screen_start held high through done and 10 more cycles → no second box. Drop for 1 cycle then raise → new box accepted.
